// File: rtl/mandel_iter_engine_if.sv
// Job/result handshake bundle for mandel_iter_engine.
// Parameters mirror the engine: FP_BITS (datapath width), FP_FRAC (fraction bits),
// ITER_WIDTH (iteration counter width), PIXEL_WIDTH (pixel tag width).
// Signals:
//   in_valid/in_ready     job request / engine idle
//   c_re, c_im            signed fixed-point coordinate c
//   iter_max              iteration limit
//   xpixel_in, ypixel_in  pixel tag echoed with the result
//   out_valid/out_ready   result available / consumer accepts
//   iterations, escaped   z-updates performed, |z|^2 >= 4 at termination
//   xpixel_out, ypixel_out tag of the current result
// Modports: master = job producer / result consumer, slave = engine.
interface mandel_iter_engine_if #(
  parameter int unsigned FP_BITS     = 32,
  parameter int unsigned FP_FRAC     = 24,
  parameter int unsigned ITER_WIDTH  = 8,
  parameter int unsigned PIXEL_WIDTH = 10
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [FP_BITS-1:0]     c_re;
  logic signed [FP_BITS-1:0]     c_im;
  logic        [ITER_WIDTH-1:0]  iter_max;
  logic        [PIXEL_WIDTH-1:0] xpixel_in;
  logic        [PIXEL_WIDTH-1:0] ypixel_in;
  logic                          out_valid;
  logic                          out_ready;
  logic        [ITER_WIDTH-1:0]  iterations;
  logic                          escaped;
  logic        [PIXEL_WIDTH-1:0] xpixel_out;
  logic        [PIXEL_WIDTH-1:0] ypixel_out;

  modport master (
    output in_valid, c_re, c_im, iter_max, xpixel_in, ypixel_in, out_ready,
    input  in_ready, out_valid, iterations, escaped, xpixel_out, ypixel_out
  );

  modport slave (
    input  in_valid, c_re, c_im, iter_max, xpixel_in, ypixel_in, out_ready,
    output in_ready, out_valid, iterations, escaped, xpixel_out, ypixel_out
  );
endinterface

// File: rtl/mandel_iter_engine.sv
// Mandelbrot escape-time engine: iterates z <= z^2 + c from z = 0, one z-update per cycle,
// until |z|^2 >= 4 or iter_max updates have been performed, then presents the count.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; aborts any job in progress
//   bus      mandel_iter_engine_if.slave (job in, result out, valid/ready both ways)
// Optional feature: define MANDEL_BULB_SKIP_EN to short-circuit points inside the
// period-2 bulb ((c_re+1)^2 + c_im^2 < 1/16) on the first iteration cycle.
module mandel_iter_engine #(
  parameter int unsigned FP_BITS     = 32,
  parameter int unsigned FP_FRAC     = 24,
  parameter int unsigned ITER_WIDTH  = 8,
  parameter int unsigned PIXEL_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mandel_iter_engine_if.slave  bus
);

  localparam int unsigned ProdW = 2 * FP_BITS;
  localparam int unsigned WideW = 2 * FP_BITS + 1;

  // 4.0 in the widened magnitude domain
  localparam logic signed [WideW-1:0] EscLimit =
      {{(WideW - FP_FRAC - 3){1'b0}}, 3'b100, {FP_FRAC{1'b0}}};

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e                   r_state;
  logic signed [FP_BITS-1:0] r_zr, r_zi, r_c_re, r_c_im;
  logic [ITER_WIDTH-1:0]    r_iter_max, r_count, r_iterations;
  logic                     r_escaped, r_out_valid;
  logic [PIXEL_WIDTH-1:0]   r_xpix_job, r_ypix_job, r_xpix_out, r_ypix_out;

  logic signed [ProdW-1:0]  w_zr_ext, w_zi_ext;
  logic signed [ProdW-1:0]  w_p_rr, w_p_ii, w_p_ri;
  logic signed [WideW-1:0]  w_rr_wide, w_ii_wide, w_mag;
  logic                     w_esc;
  logic [FP_BITS-1:0]       w_zr_next, w_zi_next;

  // Operands are sign-extended first so the products are full-width signed.
  assign w_zr_ext = {{FP_BITS{r_zr[FP_BITS-1]}}, r_zr};
  assign w_zi_ext = {{FP_BITS{r_zi[FP_BITS-1]}}, r_zi};
  assign w_p_rr   = w_zr_ext * w_zr_ext;
  assign w_p_ii   = w_zi_ext * w_zi_ext;
  assign w_p_ri   = w_zr_ext * w_zi_ext;

  // One extra bit so the sum of squares (and their difference) never overflows.
  assign w_rr_wide = {w_p_rr[ProdW-1], w_p_rr};
  assign w_ii_wide = {w_p_ii[ProdW-1], w_p_ii};
  assign w_mag     = (w_rr_wide + w_ii_wide) >>> FP_FRAC;
  assign w_esc     = (w_mag >= EscLimit);

  // Truncation to FP_BITS wraps; adding c after truncation is equivalent modulo 2^FP_BITS.
  assign w_zr_next = FP_BITS'((w_rr_wide - w_ii_wide) >>> FP_FRAC) + r_c_re;
  assign w_zi_next = FP_BITS'(w_p_ri >>> (FP_FRAC - 1)) + r_c_im;

`ifdef MANDEL_BULB_SKIP_EN
  localparam logic [FP_BITS-1:0]      FpOne     = {{(FP_BITS - FP_FRAC - 1){1'b0}}, 1'b1,
                                                   {FP_FRAC{1'b0}}};
  // 1/16 in the widened domain
  localparam logic signed [WideW-1:0] BulbLimit = {{(WideW - FP_FRAC + 3){1'b0}}, 1'b1,
                                                   {(FP_FRAC - 4){1'b0}}};

  logic [FP_BITS-1:0]       w_q;
  logic signed [ProdW-1:0]  w_q_ext, w_ci_ext, w_p_qq, w_p_cc;
  logic signed [WideW-1:0]  w_bulb_mag;
  logic                     w_bulb_hit;

  assign w_q        = r_c_re + FpOne;
  assign w_q_ext    = {{FP_BITS{w_q[FP_BITS-1]}}, w_q};
  assign w_ci_ext   = {{FP_BITS{r_c_im[FP_BITS-1]}}, r_c_im};
  assign w_p_qq     = w_q_ext * w_q_ext;
  assign w_p_cc     = w_ci_ext * w_ci_ext;
  assign w_bulb_mag = ({w_p_qq[ProdW-1], w_p_qq} + {w_p_cc[ProdW-1], w_p_cc}) >>> FP_FRAC;
  // count is zero only on the first iteration cycle of a job
  assign w_bulb_hit = (r_count == '0) && (w_bulb_mag < BulbLimit);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_zr         <= '0;
      r_zi         <= '0;
      r_c_re       <= '0;
      r_c_im       <= '0;
      r_iter_max   <= '0;
      r_count      <= '0;
      r_iterations <= '0;
      r_escaped    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_xpix_job   <= '0;
      r_ypix_job   <= '0;
      r_xpix_out   <= '0;
      r_ypix_out   <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            r_c_re     <= bus.c_re;
            r_c_im     <= bus.c_im;
            r_iter_max <= bus.iter_max;
            r_xpix_job <= bus.xpixel_in;
            r_ypix_job <= bus.ypixel_in;
            r_zr       <= '0;
            r_zi       <= '0;
            r_count    <= '0;
            r_state    <= StIter;
          end
        end
        StIter: begin
`ifdef MANDEL_BULB_SKIP_EN
          if (w_bulb_hit) begin
            r_iterations <= r_iter_max;
            r_escaped    <= 1'b0;
            r_xpix_out   <= r_xpix_job;
            r_ypix_out   <= r_ypix_job;
            r_out_valid  <= 1'b1;
            r_state      <= StDone;
          end else
`endif
          if (w_esc || (r_count == r_iter_max)) begin
            r_iterations <= r_count;
            r_escaped    <= w_esc;
            r_xpix_out   <= r_xpix_job;
            r_ypix_out   <= r_ypix_job;
            r_out_valid  <= 1'b1;
            r_state      <= StDone;
          end else begin
            r_zr    <= w_zr_next;
            r_zi    <= w_zi_next;
            r_count <= r_count + ITER_WIDTH'(1);
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.in_ready   = (r_state == StIdle);
  assign bus.out_valid  = r_out_valid;
  assign bus.iterations = r_iterations;
  assign bus.escaped    = r_escaped;
  assign bus.xpixel_out = r_xpix_out;
  assign bus.ypixel_out = r_ypix_out;

endmodule

// File: tb/tb_mandel_iter_engine.sv
// Self-checking bench for mandel_iter_engine: directed corner jobs plus randomized jobs,
// each compared against a plain-arithmetic escape-time model.
module tb_mandel_iter_engine;

  localparam int unsigned FpBits = 32;
  localparam int unsigned FpFrac = 24;
  localparam int unsigned IterW  = 8;
  localparam int unsigned PixW   = 10;
  localparam int          One    = 32'h0100_0000;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  mandel_iter_engine_if #(
    .FP_BITS(FpBits), .FP_FRAC(FpFrac), .ITER_WIDTH(IterW), .PIXEL_WIDTH(PixW)
  ) bus ();

  mandel_iter_engine #(
    .FP_BITS(FpBits), .FP_FRAC(FpFrac), .ITER_WIDTH(IterW), .PIXEL_WIDTH(PixW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Escape-time reference: z starts at 0, each step is z^2 + c in Q8.24 with
  // floor shifts and 32-bit wrap; terminates on |z|^2 >= 4 or after imax updates.
  function automatic void ref_model(input int cre, input int cim, input int unsigned imax,
                                    output int unsigned iters, output bit esc,
                                    output int unsigned lat);
    int zr = 0;
    int zi = 0;
    logic signed [64:0] a, b, m;
`ifdef MANDEL_BULB_SKIP_EN
    int q;
    q = cre + One;
    a = longint'(q) * longint'(q);
    b = longint'(cim) * longint'(cim);
    m = (a + b) >>> FpFrac;
    if (m < 65'sd1048576) begin
      iters = imax; esc = 1'b0; lat = 1;
      return;
    end
`endif
    for (int unsigned n = 0; n <= imax; n++) begin
      longint rr, ii, ri;
      rr = longint'(zr) * longint'(zr);
      ii = longint'(zi) * longint'(zi);
      ri = longint'(zr) * longint'(zi);
      a  = rr;
      b  = ii;
      m  = (a + b) >>> FpFrac;
      if (m >= 65'sd67108864 || n == imax) begin
        iters = n; esc = (m >= 65'sd67108864); lat = n + 1;
        return;
      end
      zr = int'((rr - ii) >>> FpFrac) + cre;
      zi = int'(ri >>> (FpFrac - 1)) + cim;
    end
    iters = imax; esc = 1'b0; lat = imax + 1;
  endfunction

  task automatic scramble();
    bus.c_re      = int'($urandom);
    bus.c_im      = int'($urandom);
    bus.iter_max  = IterW'($urandom);
    bus.xpixel_in = PixW'($urandom);
    bus.ypixel_in = PixW'($urandom);
  endtask

  // Called #1 after a rising edge with the engine idle.
  task automatic run_job(input int cre, input int cim, input int unsigned imax,
                         input int unsigned xp, input int unsigned yp, input int unsigned hold);
    int unsigned e_it, e_lat, lat;
    bit          e_esc;
    ref_model(cre, cim, imax, e_it, e_esc, e_lat);
    bus.c_re      = cre;
    bus.c_im      = cim;
    bus.iter_max  = IterW'(imax);
    bus.xpixel_in = PixW'(xp);
    bus.ypixel_in = PixW'(yp);
    bus.in_valid  = 1'b1;
    check("in_ready_idle", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble();
    check("in_ready_busy", bus.in_ready, 0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!bus.out_valid && lat % 7 == 0) scramble();
    end while (!bus.out_valid && lat < e_lat + 5);
    check("latency", lat, e_lat);
    check("iterations", bus.iterations, e_it);
    check("escaped", bus.escaped, e_esc);
    check("xpixel_out", bus.xpixel_out, xp);
    check("ypixel_out", bus.ypixel_out, yp);
    for (int i = 0; i < int'(hold); i++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1);
      check("hold_iterations", bus.iterations, e_it);
      check("hold_escaped", bus.escaped, e_esc);
      check("hold_xpixel", bus.xpixel_out, xp);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("drain_valid", bus.out_valid, 0);
    check("drain_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    scramble();
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_iterations", bus.iterations, 0);
    check("rst_escaped", bus.escaped, 0);
    check("rst_xpixel", bus.xpixel_out, 0);
    check("rst_ypixel", bus.ypixel_out, 0);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", bus.in_ready, 1);

    // Directed corners
    run_job(0, 0, 20, 1, 2, 0);
    run_job(One, 0, 50, 3, 4, 0);
    run_job(0, 0, 0, 639, 479, 0);
    run_job(-One, 0, 100, 5, 6, 0);
    run_job(One, 0, 50, 7, 8, 5);
    run_job(32'sh0080_0000, 32'sh0080_0000, 255, 9, 10, 1);
    run_job(-2 * One, 0, 255, 11, 12, 0);

    // Reset mid-iteration aborts the job with no result
    bus.c_re = 0; bus.c_im = 0; bus.iter_max = 8'd200; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_iterations", bus.iterations, 0);
    check("abort_xpixel", bus.xpixel_out, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    check("abort_in_ready", bus.in_ready, 1);
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_no_valid", bus.out_valid, 0);
    end
    run_job(One, 0, 50, 13, 14, 0);

    // Randomized jobs over the region around the set
    for (int k = 0; k < 40; k++) begin
      int cre, cim;
      cre = int'($urandom_range(0, 32'h0400_0000)) - 32'sh0280_0000;
      cim = int'($urandom_range(0, 32'h0300_0000)) - 32'sh0180_0000;
      run_job(cre, cim, $urandom_range(0, 60), $urandom_range(0, 1023),
              $urandom_range(0, 1023), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mandel_iter_engine.md
MANDEL_ITER_ENGINE -- requirements
Module: mandel_iter_engine

Interface
REQ-001 FP_BITS, 32, signed fixed-point datapath width.
REQ-002 FP_FRAC, 24, fraction bits (Q(FP_BITS-FP_FRAC).FP_FRAC); the block SHALL require 2 < FP_BITS-FP_FRAC.
REQ-003 ITER_WIDTH, 8, iteration counter width.
REQ-004 PIXEL_WIDTH, 10, pixel tag width.
REQ-005 One clock; reset is asynchronous and active-low; ports SHALL be named clk and reset_n.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 in_valid  in  1  job request; in_ready  out  1  engine idle.
REQ-009 c_re, c_im  in  FP_BITS each  signed complex coordinate c.
REQ-010 iter_max  in  ITER_WIDTH  iteration limit.
REQ-011 xpixel_in, ypixel_in  in  PIXEL_WIDTH each  pixel tag, returned unchanged.
REQ-012 out_valid  out  1  result available; out_ready  in  1  consumer accepts.
REQ-013 iterations  out  ITER_WIDTH  z-updates performed; escaped  out  1  |z|^2>=4 at termination.
REQ-014 xpixel_out, ypixel_out  out  PIXEL_WIDTH each  tag of current result.

Function
REQ-015 States SHALL be IDLE, ITER, DONE; in_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: on in_valid&in_ready the block SHALL latch c, iter_max, tags, clear z=0 and count=0, and enter ITER.
REQ-017 ITER, each cycle: mag = (zr*zr + zi*zi) >>> FP_FRAC, computed at 2*FP_BITS+1 bits without overflow; esc = mag >= (4 << FP_FRAC).
REQ-018 ITER: if esc or count==iter_max, go to DONE with iterations=count, escaped=esc, out_valid=1; esc SHALL take precedence in setting escaped when both hold.
REQ-019 ITER otherwise: zr <= ((zr*zr - zi*zi) >>> FP_FRAC) + c_re, zi <= ((zr*zi) >>> (FP_FRAC-1)) + c_im, count <= count+1.
REQ-020 Products SHALL be full 2*FP_BITS signed; the shift is arithmetic (round toward -inf); results are truncated to FP_BITS (two's-complement wrap, no saturation).
REQ-021 Latency: a result with iterations=n SHALL assert out_valid exactly n+1 rising edges after the acceptance edge.
REQ-022 DONE: outputs SHALL hold stable while out_ready=0; on out_valid&out_ready the block SHALL clear out_valid and return to IDLE (accepting the next job no earlier than the following cycle).
REQ-023 iter_max=0 SHALL give iterations=0, escaped=0 (z=0).
REQ-024 Inputs other than handshakes SHALL be ignored outside the acceptance cycle.

Reset
REQ-025 reset_n low SHALL immediately force state IDLE, out_valid=0, iterations=0, escaped=0, xpixel_out=0, ypixel_out=0, z=0, count=0, aborting any job in progress with no output.
REQ-026 in_ready SHALL be 1 in the first cycle after reset_n deasserts.

Configuration
REQ-027 Macro MANDEL_BULB_SKIP_EN: when defined, in the first ITER cycle the block SHALL evaluate (c_re+1)^2 + c_im^2 < 1/16 (same arithmetic rules) and, if true, enter DONE with iterations=iter_max, escaped=0 (latency 1 edge).
REQ-028 Without MANDEL_BULB_SKIP_EN no bulb logic SHALL exist and every job iterates per REQ-017..019.

Verification (FP_BITS=32, FP_FRAC=24)
REQ-029 c=(0,0), iter_max=20 -> iterations=20, escaped=0, out_valid 21 edges after acceptance.
REQ-030 c=(1.0,0)=(0x01000000,0), iter_max=50 -> z: 1, 2; iterations=2, escaped=1, out_valid 3 edges after acceptance.
REQ-031 c=(0,0), iter_max=0 -> iterations=0, escaped=0, out_valid 1 edge after acceptance; tags xpixel=639, ypixel=479 echoed.
REQ-032 Result ready, out_ready held 0 for 5 cycles -> all outputs stable, in_ready=0; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-033 reset_n pulsed low mid-ITER (c=(0,0), iter_max=200) -> outputs zero immediately, no out_valid, next job c=(1.0,0) yields iterations=2.
REQ-034 c=(-1.0,0), iter_max=100 -> with MANDEL_BULB_SKIP_EN: iterations=100, escaped=0 after 1 edge; without: same values after 101 edges.
